// File: rtl/note_event_sequencer_pkg.sv
// Shared definitions for the note event sequencer and its neighbours.
// Holds default sizing, the time limit, and the sequencer state encoding.
package note_event_sequencer_pkg;

    localparam int          NUM_KEYS_DEF = 8;
    localparam int          DEPTH_DEF    = 64;
    localparam int          TS_W_DEF     = 29;
    localparam int unsigned TS_MAX_DEF   = 32'd300_000_000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RECORD,
        ST_PLAY_FETCH,
        ST_PLAY_WAIT,
        ST_PLAY_DONE
    } seq_state_e;

endpackage

// File: rtl/note_event_sequencer_event_mem.sv
// Simple dual-port event RAM: synchronous write, registered synchronous read.
// The read register only loads on rd_en so fetched data holds while waiting.
module event_mem #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 37
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // NOTE: the array and read register have no reset so the RAM maps onto block memory.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/note_event_sequencer.sv
// Records timestamped key-state changes and replays them against the shared
// microsecond timestamp; also drives the time counter's enable and clear.
module note_event_sequencer
    import note_event_sequencer_pkg::*;
#(
    parameter int          NUM_KEYS = NUM_KEYS_DEF,
    parameter int          DEPTH    = DEPTH_DEF,
    parameter int          TS_W     = TS_W_DEF,
    parameter int unsigned TS_MAX   = TS_MAX_DEF
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     start_record,
    input  logic                     start_play,
    input  logic                     stop,
    input  logic [NUM_KEYS-1:0]      key_state,
    input  logic [TS_W-1:0]          timestamp,
    output logic                     timer_enable,
    output logic                     timer_clear,
    output logic [NUM_KEYS-1:0]      play_keys,
    output logic                     busy,
    output logic                     full,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   event_count
);

    localparam int              AW      = $clog2(DEPTH);
    localparam int              CW      = AW + 1;
    localparam int              MW      = TS_W + NUM_KEYS;
    localparam logic [TS_W-1:0] TS_LAST = TS_W'(TS_MAX);

    seq_state_e          state_q, state_d;
    logic [CW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       event_count_q, event_count_d;
    logic [NUM_KEYS-1:0] prev_keys_q, prev_keys_d;
    logic [NUM_KEYS-1:0] play_keys_q, play_keys_d;
    logic                overflow_q, overflow_d;

    logic                mem_we, mem_re;
    logic [MW-1:0]       mem_rdata;
    logic [TS_W-1:0]     cur_ts;
    logic [NUM_KEYS-1:0] cur_keys;
    logic                full_w;

    // The write pointer is the event count itself; it never advances past a full memory.
    event_mem #(
        .DEPTH (DEPTH),
        .WIDTH (MW)
    ) u_event_mem (
        .clk     (clk),
        .wr_en   (mem_we),
        .wr_addr (event_count_q[AW-1:0]),
        .wr_data ({timestamp, key_state}),
        .rd_en   (mem_re),
        .rd_addr (rd_ptr_q[AW-1:0]),
        .rd_data (mem_rdata)
    );

    assign cur_keys = mem_rdata[NUM_KEYS-1:0];
    assign cur_ts   = mem_rdata[NUM_KEYS +: TS_W];
    assign full_w   = (event_count_q == CW'(DEPTH));

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned and no latch is inferred.
        state_d       = state_q;
        rd_ptr_d      = rd_ptr_q;
        event_count_d = event_count_q;
        prev_keys_d   = prev_keys_q;
        play_keys_d   = play_keys_q;
        overflow_d    = overflow_q;
        mem_we        = 1'b0;
        mem_re        = 1'b0;
        timer_enable  = 1'b0;
        timer_clear   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_record) begin
                    state_d       = ST_RECORD;
                    timer_clear   = 1'b1;
                    event_count_d = '0;
                    overflow_d    = 1'b0;
                    prev_keys_d   = '0;
                end else if (start_play && (event_count_q != '0)) begin
                    state_d     = ST_PLAY_FETCH;
                    timer_clear = 1'b1;
                    rd_ptr_d    = '0;
                end
            end

            ST_RECORD: begin
                timer_enable = 1'b1;
                if (stop) begin
                    state_d = ST_IDLE;
                end else begin
                    if (key_state != prev_keys_q) begin
                        prev_keys_d = key_state;
                        if (full_w) begin
                            overflow_d = 1'b1;
                        end else begin
                            mem_we        = 1'b1;
                            event_count_d = event_count_q + CW'(1);
                        end
                    end
                    if (timestamp == TS_LAST) begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_PLAY_FETCH: begin
                if (stop) begin
                    play_keys_d = '0;
                    state_d     = ST_IDLE;
                end else begin
                    timer_enable = 1'b1;
                    mem_re       = 1'b1;
                    state_d      = ST_PLAY_WAIT;
                end
            end

            ST_PLAY_WAIT: begin
                if (stop) begin
                    play_keys_d = '0;
                    state_d     = ST_IDLE;
                end else begin
                    timer_enable = 1'b1;
                    if (timestamp >= cur_ts) begin
                        play_keys_d = cur_keys;
                        rd_ptr_d    = rd_ptr_q + CW'(1);
                        state_d     = (rd_ptr_d == event_count_q) ? ST_PLAY_DONE : ST_PLAY_FETCH;
                    end
                end
            end

            ST_PLAY_DONE: begin
                play_keys_d = '0;
                state_d     = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values together.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            rd_ptr_q      <= '0;
            event_count_q <= '0;
            prev_keys_q   <= '0;
            play_keys_q   <= '0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            rd_ptr_q      <= rd_ptr_d;
            event_count_q <= event_count_d;
            prev_keys_q   <= prev_keys_d;
            play_keys_q   <= play_keys_d;
            overflow_q    <= overflow_d;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign full        = full_w;
    assign overflow    = overflow_q;
    assign play_keys   = play_keys_q;
    assign event_count = event_count_q;

endmodule

// File: tb/tb_note_event_sequencer.sv
// Directed bench for note_event_sequencer: the bench plays the time counter by
// driving timestamp directly, and checks against hand-computed expectations.
module tb_note_event_sequencer;

    localparam int          NK     = 8;
    localparam int          TSW    = 29;
    localparam int unsigned TS_MAX = 32'd300_000_000;

    logic           clk = 1'b0;
    logic           resetn = 1'b0;
    logic           start_record = 1'b0;
    logic           start_play = 1'b0;
    logic           stop = 1'b0;
    logic [NK-1:0]  key_state = '0;
    logic [TSW-1:0] timestamp = '0;

    logic           timer_enable, timer_clear, busy, full, overflow;
    logic [NK-1:0]  play_keys;
    logic [6:0]     event_count;

    int checks = 0;
    int failures = 0;
    int clr_cnt = 0;

    note_event_sequencer dut (
        .clk          (clk),
        .resetn       (resetn),
        .start_record (start_record),
        .start_play   (start_play),
        .stop         (stop),
        .key_state    (key_state),
        .timestamp    (timestamp),
        .timer_enable (timer_enable),
        .timer_clear  (timer_clear),
        .play_keys    (play_keys),
        .busy         (busy),
        .full         (full),
        .overflow     (overflow),
        .event_count  (event_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic           sr, sp, st;
        logic [NK-1:0]  keys;
        logic [TSW-1:0] ts;
        logic           busy, en;
        logic [6:0]     cnt;
        logic [NK-1:0]  play;
    } vec_t;

    vec_t tab [18];

    function automatic vec_t mk(input logic sr, input logic sp, input logic st,
                                input logic [NK-1:0] k, input logic [TSW-1:0] t,
                                input logic b, input logic e,
                                input logic [6:0] c, input logic [NK-1:0] p);
        vec_t v;
        v.sr = sr; v.sp = sp; v.st = st; v.keys = k; v.ts = t;
        v.busy = b; v.en = e; v.cnt = c; v.play = p;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One clock: clear pulses are counted mid-cycle, outputs settle 1ns after the edge.
    task automatic tick();
        @(negedge clk);
        if (timer_clear) clr_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int idx);
        vec_t x;
        x = tab[idx];
        start_record = x.sr;
        start_play   = x.sp;
        stop         = x.st;
        key_state    = x.keys;
        timestamp    = x.ts;
        tick();
        start_record = 1'b0;
        start_play   = 1'b0;
        stop         = 1'b0;
        #1;
        check($sformatf("vec%0d_busy", idx), 64'(busy), 64'(x.busy));
        check($sformatf("vec%0d_timer_enable", idx), 64'(timer_enable), 64'(x.en));
        check($sformatf("vec%0d_event_count", idx), 64'(event_count), 64'(x.cnt));
        check($sformatf("vec%0d_play_keys", idx), 64'(play_keys), 64'(x.play));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Record 1@100, 3@250, 0@400 (a start_play mid-record must be ignored), then replay it.
        tab[0]  = mk(1, 0, 0, 8'h00,   0, 1, 1, 0, 8'h00);
        tab[1]  = mk(0, 0, 0, 8'h00,  50, 1, 1, 0, 8'h00);
        tab[2]  = mk(0, 0, 0, 8'h01, 100, 1, 1, 1, 8'h00);
        tab[3]  = mk(0, 0, 0, 8'h01, 180, 1, 1, 1, 8'h00);
        tab[4]  = mk(0, 0, 0, 8'h03, 250, 1, 1, 2, 8'h00);
        tab[5]  = mk(0, 1, 0, 8'h03, 300, 1, 1, 2, 8'h00);
        tab[6]  = mk(0, 0, 0, 8'h00, 400, 1, 1, 3, 8'h00);
        tab[7]  = mk(0, 0, 1, 8'h00, 401, 0, 0, 3, 8'h00);
        tab[8]  = mk(0, 1, 0, 8'h00,   0, 1, 1, 3, 8'h00);
        tab[9]  = mk(0, 0, 0, 8'h00,   0, 1, 1, 3, 8'h00);
        tab[10] = mk(0, 0, 0, 8'h00,  99, 1, 1, 3, 8'h00);
        tab[11] = mk(0, 0, 0, 8'h00, 100, 1, 1, 3, 8'h01);
        tab[12] = mk(0, 0, 0, 8'h00, 101, 1, 1, 3, 8'h01);
        tab[13] = mk(0, 0, 0, 8'h00, 249, 1, 1, 3, 8'h01);
        tab[14] = mk(0, 0, 0, 8'h00, 250, 1, 1, 3, 8'h03);
        tab[15] = mk(0, 0, 0, 8'h00, 251, 1, 1, 3, 8'h03);
        tab[16] = mk(0, 0, 0, 8'h00, 400, 1, 0, 3, 8'h00);
        tab[17] = mk(0, 0, 0, 8'h00, 401, 0, 0, 3, 8'h00);

        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_timer_enable", 64'(timer_enable), 64'd0);
        check("reset_timer_clear", 64'(timer_clear), 64'd0);
        check("reset_event_count", 64'(event_count), 64'd0);
        check("reset_full", 64'(full), 64'd0);
        check("reset_overflow", 64'(overflow), 64'd0);
        check("reset_play_keys", 64'(play_keys), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) run_vec(i);
        check("record_clear_pulses", 64'(clr_cnt), 64'd1);
        for (int i = 8; i < 18; i++) run_vec(i);
        check("play_clear_pulses", 64'(clr_cnt), 64'd2);

        // Stop during PLAY_WAIT, then a fresh playback must restart at event 0.
        start_play = 1'b1; timestamp = '0;
        tick();
        start_play = 1'b0;
        tick();
        timestamp = 29'd100;
        tick();
        tick();
        check("stop_pre_play_keys", 64'(play_keys), 64'h01);
        stop = 1'b1;
        #1;
        check("stop_timer_enable", 64'(timer_enable), 64'd0);
        tick();
        stop = 1'b0;
        #1;
        check("stop_play_keys", 64'(play_keys), 64'd0);
        check("stop_busy", 64'(busy), 64'd0);
        start_play = 1'b1; timestamp = '0;
        tick();
        start_play = 1'b0;
        tick();
        timestamp = 29'd100;
        tick();
        check("replay_from_zero", 64'(play_keys), 64'h01);
        stop = 1'b1;
        tick();
        stop = 1'b0;

        // Fill: 70 changes, keys i+1 at ts 10i+10; only the first 64 may land.
        start_record = 1'b1; key_state = '0; timestamp = '0;
        tick();
        start_record = 1'b0;
        for (int i = 0; i < 70; i++) begin
            key_state = 8'(i + 1);
            timestamp = 29'(10 * i + 10);
            tick();
            if (i == 62) check("full_at_63", 64'(full), 64'd0);
            if (i == 63) begin
                check("full_at_64", 64'(full), 64'd1);
                check("overflow_at_64", 64'(overflow), 64'd0);
            end
        end
        check("fill_event_count", 64'(event_count), 64'd64);
        check("fill_full", 64'(full), 64'd1);
        check("fill_overflow", 64'(overflow), 64'd1);
        stop = 1'b1;
        tick();
        stop = 1'b0;

        start_play = 1'b1; timestamp = '0;
        tick();
        start_play = 1'b0;
        for (int k = 0; k < 64; k++) begin
            int n;
            n = 0;
            timestamp = 29'(10 * k + 10);
            while (play_keys != 8'(k + 1) && n < 6) begin
                tick();
                n++;
            end
            check($sformatf("full_replay_%0d", k), 64'(play_keys), 64'(k + 1));
        end
        begin
            int n;
            n = 0;
            while (busy && n < 6) begin
                tick();
                n++;
            end
        end
        check("full_replay_done_busy", 64'(busy), 64'd0);
        check("full_replay_done_keys", 64'(play_keys), 64'd0);

        // Record and play requested together: record wins and clears the old take.
        start_record = 1'b1; start_play = 1'b1; key_state = '0; timestamp = '0;
        tick();
        start_record = 1'b0; start_play = 1'b0;
        #1;
        check("prio_busy", 64'(busy), 64'd1);
        check("prio_event_count", 64'(event_count), 64'd0);
        check("prio_overflow", 64'(overflow), 64'd0);
        check("prio_full", 64'(full), 64'd0);
        for (int i = 0; i < 5; i++) begin
            key_state = 8'(i + 1);
            timestamp = 29'(10 * i + 10);
            tick();
        end
        check("prio_five_events", 64'(event_count), 64'd5);

        // Asynchronous reset mid-record, away from any clock edge.
        @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        check("async_reset_busy", 64'(busy), 64'd0);
        check("async_reset_timer_enable", 64'(timer_enable), 64'd0);
        check("async_reset_event_count", 64'(event_count), 64'd0);
        check("async_reset_play_keys", 64'(play_keys), 64'd0);
        check("async_reset_overflow", 64'(overflow), 64'd0);
        key_state = '0;
        @(negedge clk);
        resetn = 1'b1;
        tick();

        // Time limit ends recording without stop; an empty playback request is ignored.
        start_record = 1'b1; timestamp = '0;
        tick();
        start_record = 1'b0;
        timestamp = 29'(TS_MAX - 1);
        tick();
        check("tlimit_before_busy", 64'(busy), 64'd1);
        timestamp = 29'(TS_MAX);
        tick();
        check("tlimit_busy", 64'(busy), 64'd0);
        check("tlimit_timer_enable", 64'(timer_enable), 64'd0);
        check("tlimit_event_count", 64'(event_count), 64'd0);
        start_play = 1'b1;
        #1;
        check("empty_play_timer_clear", 64'(timer_clear), 64'd0);
        tick();
        start_play = 1'b0;
        check("empty_play_busy", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
